// File: rtl/disp_pattern_rot.sv
// rtl/disp_pattern_rot.sv - four loadable 8-bit digit patterns with debounced loads and timed rotation
// Feeds the 4-digit 7-segment multiplexer; segments are active-low, so FF blanks a digit.

module disp_pattern_rot_btn #(
  parameter int DB_W = 19
) (
  input  logic clk,
  input  logic reset_n,
  input  logic btn,
  output logic level
);

  localparam logic [DB_W-1:0] CNT_ONE = {{(DB_W-1){1'b0}}, 1'b1};

  logic            sync1;
  logic            sync2;
  logic [DB_W-1:0] cnt;

  // Any sample that agrees with the accepted level restarts the stability window.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      cnt   <= '0;
      level <= 1'b0;
    end else begin
      sync1 <= btn;
      sync2 <= sync1;
      if (sync2 == level) begin
        cnt <= '0;
      end else if (&cnt) begin
        level <= sync2;
        cnt   <= '0;
      end else begin
        cnt <= cnt + CNT_ONE;
      end
    end
  end

endmodule

module disp_pattern_rot #(
  parameter int DB_W   = 19,
  parameter int TICK_W = 24
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [3:0] btn,
  input  logic [7:0] sw,
  input  logic       rot_en,
  input  logic       rot_dir,
  output logic [7:0] in0,
  output logic [7:0] in1,
  output logic [7:0] in2,
  output logic [7:0] in3,
  output logic [3:0] load_pulse
);

  localparam logic [TICK_W-1:0] TICK_ONE = {{(TICK_W-1){1'b0}}, 1'b1};

  logic [3:0]        db_level;
  logic [3:0]        db_level_d;
  logic [TICK_W-1:0] tcnt;
  logic              tick;
  logic [7:0]        nxt0;
  logic [7:0]        nxt1;
  logic [7:0]        nxt2;
  logic [7:0]        nxt3;

  for (genvar i = 0; i < 4; i++) begin : g_btn
    disp_pattern_rot_btn #(.DB_W(DB_W)) u_btn (
      .clk     (clk),
      .reset_n (reset_n),
      .btn     (btn[i]),
      .level   (db_level[i])
    );
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      db_level_d <= '0;
    end else begin
      db_level_d <= db_level;
    end
  end

  assign load_pulse = db_level & ~db_level_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tcnt <= '0;
    end else if (!rot_en) begin
      tcnt <= '0;
    end else begin
      tcnt <= tcnt + TICK_ONE;
    end
  end

  assign tick = rot_en & (&tcnt);

  // A load overrides whatever would have rotated into its slot.
  always_comb begin
    nxt0 = in0;
    nxt1 = in1;
    nxt2 = in2;
    nxt3 = in3;
    if (tick) begin
      if (rot_dir) begin
        nxt0 = in1;
        nxt1 = in2;
        nxt2 = in3;
        nxt3 = in0;
      end else begin
        nxt0 = in3;
        nxt1 = in0;
        nxt2 = in1;
        nxt3 = in2;
      end
    end
    if (load_pulse[0]) nxt0 = sw;
    if (load_pulse[1]) nxt1 = sw;
    if (load_pulse[2]) nxt2 = sw;
    if (load_pulse[3]) nxt3 = sw;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      in0 <= 8'hFF;
      in1 <= 8'hFF;
      in2 <= 8'hFF;
      in3 <= 8'hFF;
    end else begin
      in0 <= nxt0;
      in1 <= nxt1;
      in2 <= nxt2;
      in3 <= nxt3;
    end
  end

endmodule

// File: tb/tb_disp_pattern_rot.sv
// tb/tb_disp_pattern_rot.sv - self-checking bench for disp_pattern_rot
module tb_disp_pattern_rot;

  localparam int DB_W   = 2;
  localparam int TICK_W = 3;
  localparam int NDB    = 1 << DB_W;
  localparam int NT     = 1 << TICK_W;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [3:0] btn;
  logic [7:0] sw;
  logic       rot_en;
  logic       rot_dir;
  logic [7:0] in0, in1, in2, in3;
  logic [3:0] load_pulse;

  int checks = 0;
  int errors = 0;

  disp_pattern_rot #(.DB_W(DB_W), .TICK_W(TICK_W)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .btn        (btn),
    .sw         (sw),
    .rot_en     (rot_en),
    .rot_dir    (rot_dir),
    .in0        (in0),
    .in1        (in1),
    .in2        (in2),
    .in3        (in3),
    .load_pulse (load_pulse)
  );

  always #5 clk = ~clk;

  // Reference: a button is accepted once its synchronised samples over the
  // last NDB edges all disagree with the accepted level.
  logic [7:0]  m_pat [4];
  logic [3:0]  m_lvl;
  logic [3:0]  m_pulse;
  logic [15:0] m_hist [4];
  int          m_en_edges;

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_pat[i]  = 8'hFF;
      m_hist[i] = '0;
    end
    m_lvl      = '0;
    m_pulse    = '0;
    m_en_edges = 0;
  endtask

  task automatic model_edge();
    logic [7:0] nxt [4];
    logic       tick;
    logic       new_lvl;
    tick       = rot_en && (((m_en_edges + 1) % NT) == 0);
    m_en_edges = rot_en ? m_en_edges + 1 : 0;
    for (int i = 0; i < 4; i++) begin
      nxt[i] = m_pat[i];
      if (tick) nxt[i] = rot_dir ? m_pat[(i + 1) % 4] : m_pat[(i + 3) % 4];
      if (m_pulse[i]) nxt[i] = sw;
    end
    for (int i = 0; i < 4; i++) begin
      m_pat[i] = nxt[i];
      new_lvl  = m_lvl[i];
      if (m_hist[i][NDB:1] == {NDB{~m_lvl[i]}}) new_lvl = ~m_lvl[i];
      m_pulse[i] = new_lvl & ~m_lvl[i];
      m_lvl[i]   = new_lvl;
      m_hist[i]  = {m_hist[i][14:0], btn[i]};
    end
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    if (reset_n) model_edge();
    else model_reset();
    @(negedge clk);
    chk("model", {28'd0, in0, in1, in2, in3, load_pulse},
        {28'd0, m_pat[0], m_pat[1], m_pat[2], m_pat[3], m_pulse});
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    #1;
    model_reset();
    chk("reset_async", {28'd0, in0, in1, in2, in3, load_pulse}, {28'd0, 32'hFFFFFFFF, 4'h0});
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  typedef struct {
    logic [3:0]  b;
    logic [7:0]  s;
    logic        en;
    logic        dir;
    int          n;
    logic [31:0] exp_pat;
    logic [3:0]  exp_pulse;
  } vec_t;

  vec_t tbl [$];

  function automatic vec_t v(input logic [3:0] b, input logic [7:0] s, input logic en,
                             input logic dir, input int n, input logic [31:0] p,
                             input logic [3:0] pl);
    vec_t r;
    r.b = b; r.s = s; r.en = en; r.dir = dir; r.n = n; r.exp_pat = p; r.exp_pulse = pl;
    return r;
  endfunction

  initial begin
    reset_n = 1'b0;
    btn = '0; sw = '0; rot_en = 1'b0; rot_dir = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    chk("reset_state", {28'd0, in0, in1, in2, in3, load_pulse}, {28'd0, 32'hFFFFFFFF, 4'h0});
    reset_n = 1'b1;

    // single load, hold, release
    tbl.push_back(v(4'b0001, 8'hC0, 0, 0, 6,  32'hFFFFFFFF, 4'b0001));
    tbl.push_back(v(4'b0001, 8'hC0, 0, 0, 1,  32'hC0FFFFFF, 4'b0000));
    tbl.push_back(v(4'b0001, 8'h11, 0, 0, 13, 32'hC0FFFFFF, 4'b0000));
    tbl.push_back(v(4'b0000, 8'h22, 0, 0, 10, 32'hC0FFFFFF, 4'b0000));
    // short press rejected
    tbl.push_back(v(4'b0100, 8'hA4, 0, 0, 3,  32'hC0FFFFFF, 4'b0000));
    tbl.push_back(v(4'b0000, 8'hA4, 0, 0, 10, 32'hC0FFFFFF, 4'b0000));
    tbl.push_back(v(4'b0010, 8'hF9, 0, 0, 7,  32'hC0F9FFFF, 4'b0000));
    tbl.push_back(v(4'b0000, 8'hF9, 0, 0, 6,  32'hC0F9FFFF, 4'b0000));
    tbl.push_back(v(4'b0100, 8'hA4, 0, 0, 7,  32'hC0F9A4FF, 4'b0000));
    tbl.push_back(v(4'b0000, 8'hA4, 0, 0, 6,  32'hC0F9A4FF, 4'b0000));
    // long press with a 3-cycle low glitch loads once
    tbl.push_back(v(4'b1000, 8'hB0, 0, 0, 7,  32'hC0F9A4B0, 4'b0000));
    tbl.push_back(v(4'b1000, 8'h55, 0, 0, 5,  32'hC0F9A4B0, 4'b0000));
    tbl.push_back(v(4'b0000, 8'h55, 0, 0, 3,  32'hC0F9A4B0, 4'b0000));
    tbl.push_back(v(4'b1000, 8'h55, 0, 0, 10, 32'hC0F9A4B0, 4'b0000));
    tbl.push_back(v(4'b0000, 8'h55, 0, 0, 6,  32'hC0F9A4B0, 4'b0000));
    // rotation left, left, right; direction sampled at the tick only
    tbl.push_back(v(4'b0000, 8'h00, 1, 0, 8,  32'hB0C0F9A4, 4'b0000));
    tbl.push_back(v(4'b0000, 8'h00, 1, 0, 8,  32'hA4B0C0F9, 4'b0000));
    tbl.push_back(v(4'b0000, 8'h00, 1, 1, 8,  32'hB0C0F9A4, 4'b0000));
    tbl.push_back(v(4'b0000, 8'h00, 1, 0, 4,  32'hB0C0F9A4, 4'b0000));
    tbl.push_back(v(4'b0000, 8'h00, 1, 1, 4,  32'hC0F9A4B0, 4'b0000));
    // load coinciding with a tick
    tbl.push_back(v(4'b0000, 8'h99, 1, 0, 1,  32'hC0F9A4B0, 4'b0000));
    tbl.push_back(v(4'b0010, 8'h99, 1, 0, 6,  32'hC0F9A4B0, 4'b0010));
    tbl.push_back(v(4'b0010, 8'h99, 1, 0, 1,  32'hB099F9A4, 4'b0000));
    tbl.push_back(v(4'b0000, 8'h99, 0, 0, 6,  32'hB099F9A4, 4'b0000));
    // two buttons in the same cycle
    tbl.push_back(v(4'b0011, 8'h3C, 0, 0, 6,  32'hB099F9A4, 4'b0011));
    tbl.push_back(v(4'b0011, 8'h3C, 0, 0, 1,  32'h3C3CF9A4, 4'b0000));
    tbl.push_back(v(4'b0000, 8'h3C, 0, 0, 6,  32'h3C3CF9A4, 4'b0000));

    foreach (tbl[k]) begin
      btn = tbl[k].b; sw = tbl[k].s; rot_en = tbl[k].en; rot_dir = tbl[k].dir;
      repeat (tbl[k].n) cyc();
      chk($sformatf("vec%0d", k), {28'd0, in0, in1, in2, in3, load_pulse},
          {28'd0, tbl[k].exp_pat, tbl[k].exp_pulse});
    end

    // reset mid-debounce and mid-period, then full latencies again
    btn = 4'b0100; sw = 8'h11; rot_en = 1'b1; rot_dir = 1'b0;
    repeat (5) cyc();
    do_reset();
    repeat (6) cyc();
    chk("rst_no_early", {28'd0, in0, in1, in2, in3, load_pulse}, {28'd0, 32'hFFFFFFFF, 4'b0100});
    cyc();
    chk("rst_load", {32'd0, in0, in1, in2, in3}, {32'd0, 32'hFFFF11FF});
    cyc();
    chk("rst_tick", {32'd0, in0, in1, in2, in3}, {32'd0, 32'hFFFFFF11});

    // randomized traffic against the reference
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < 4; i++)
        if ($urandom_range(0, 5) == 0) btn[i] = ~btn[i];
      sw = 8'($urandom);
      if ($urandom_range(0, 39) == 0) rot_en = ~rot_en;
      if ($urandom_range(0, 9) == 0) rot_dir = ~rot_dir;
      if ($urandom_range(0, 299) == 0) do_reset();
      else cyc();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
